// File: rtl/traffic_light_monitor_pkg.sv
// traffic_light_monitor_pkg: light encodings, fault codes and monitor states.
package traffic_light_monitor_pkg;
    typedef enum logic [1:0] {LT_RED = 2'b00, LT_GREEN = 2'b01, LT_YELLOW = 2'b10, LT_ILL = 2'b11} light_t;
    typedef enum logic [2:0] {
        FC_NONE, FC_ILLEGAL, FC_CONFLICT, FC_TRANS, FC_YELLOW, FC_GREEN, FC_EMERG
    } fault_t;
    typedef enum logic [1:0] {ST_ARM, ST_RUN, ST_FAULT} mon_state_t;
    function automatic logic legal_step(input logic [1:0] from, input logic [1:0] to);
        return (from == LT_GREEN && to == LT_YELLOW) || (from == LT_YELLOW && to == LT_RED) ||
               (from == LT_RED && to == LT_GREEN);
    endfunction
endpackage

// File: rtl/light_head_checker.sv
// light_head_checker: per-head sequencing, dwell and emergency-response checks.
module light_head_checker
    import traffic_light_monitor_pkg::*;
#(
    parameter int unsigned MIN_GREEN     = 5,
    parameter int unsigned MIN_YELLOW    = 2,
    parameter int unsigned MAX_YELLOW    = 5,
    parameter int unsigned EMERG_TIMEOUT = 3,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] light,
    input  logic       emerg,
    input  logic       buzzer,
    output logic       f_ill,
    output logic       f_trans,
    output logic       f_yellow,
    output logic       f_green,
    output logic       f_emerg
);
    localparam logic [CNT_W-1:0] MIN_G   = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MIN_Y   = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] OVER_Y  = CNT_W'(MAX_YELLOW + 1);
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(EMERG_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [1:0]       prev;
    logic [CNT_W-1:0] dwell, dwell_nxt, wait_cnt;
    logic             pend, changed;
    always_comb begin
        changed   = light != prev;
        dwell_nxt = changed ? CNT_W'(1) : (dwell == CNT_MAX ? dwell : dwell + 1'b1);
        f_ill     = light == LT_ILL;
        f_trans   = changed && !legal_step(prev, light);
        f_yellow  = (changed && prev == LT_YELLOW && dwell < MIN_Y) ||
                    (light == LT_YELLOW && dwell_nxt == OVER_Y);
        f_green   = changed && prev == LT_GREEN && dwell < MIN_G && !pend;
        f_emerg   = pend && wait_cnt == TMO && !buzzer;
    end
    // A buzzer always wins over a request seen in the same sample.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev     <= LT_RED;
            dwell    <= '0;
            pend     <= 1'b0;
            wait_cnt <= '0;
        end else begin
            prev     <= light;
            dwell    <= dwell_nxt;
            pend     <= !buzzer && (pend || emerg);
            wait_cnt <= (pend && !buzzer) ? (wait_cnt == CNT_MAX ? wait_cnt : wait_cnt + 1'b1) : '0;
        end
    end
endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker for two signal heads; latches the first
// violation as a sticky fault and counts T1 RED->GREEN entries.
module traffic_light_monitor
    import traffic_light_monitor_pkg::*;
#(
    parameter int unsigned MIN_GREEN     = 5,
    parameter int unsigned MIN_YELLOW    = 2,
    parameter int unsigned MAX_YELLOW    = 5,
    parameter int unsigned EMERG_TIMEOUT = 3,
    parameter int unsigned CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Emergency_Left,
    input  logic        Emergency_Right,
    input  logic [1:0]  T1_light,
    input  logic [1:0]  T2_light,
    input  logic        Buzzer_T1,
    input  logic        Buzzer_T2,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic [1:0]  fault_src,
    output logic [15:0] cycle_count
);
    logic [1:0] ill, trans, yel, grn, emg, src_nxt, t1_prev;
    logic [2:0] code_nxt;
    logic       conflict, t1_entry;
    mon_state_t state;
    light_head_checker #(
        .MIN_GREEN(MIN_GREEN), .MIN_YELLOW(MIN_YELLOW), .MAX_YELLOW(MAX_YELLOW),
        .EMERG_TIMEOUT(EMERG_TIMEOUT), .CNT_W(CNT_W)
    ) u_t1 (
        .clk(clk), .rst(rst), .light(T1_light), .emerg(Emergency_Left), .buzzer(Buzzer_T1),
        .f_ill(ill[0]), .f_trans(trans[0]), .f_yellow(yel[0]), .f_green(grn[0]), .f_emerg(emg[0])
    );
    light_head_checker #(
        .MIN_GREEN(MIN_GREEN), .MIN_YELLOW(MIN_YELLOW), .MAX_YELLOW(MAX_YELLOW),
        .EMERG_TIMEOUT(EMERG_TIMEOUT), .CNT_W(CNT_W)
    ) u_t2 (
        .clk(clk), .rst(rst), .light(T2_light), .emerg(Emergency_Right), .buzzer(Buzzer_T2),
        .f_ill(ill[1]), .f_trans(trans[1]), .f_yellow(yel[1]), .f_green(grn[1]), .f_emerg(emg[1])
    );
    // Lowest code wins; its source mask ORs every head that raised it.
    always_comb begin
        conflict = T1_light != LT_RED && T2_light != LT_RED;
        t1_entry = t1_prev == LT_RED && T1_light == LT_GREEN;
        code_nxt = |ill ? FC_ILLEGAL : conflict ? FC_CONFLICT : |trans ? FC_TRANS :
                   |yel ? FC_YELLOW : |grn ? FC_GREEN : |emg ? FC_EMERG : FC_NONE;
        src_nxt  = |ill ? ill : conflict ? 2'b11 : |trans ? trans : |yel ? yel : |grn ? grn : emg;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_ARM;
            t1_prev     <= LT_RED;
            fault       <= 1'b0;
            fault_code  <= FC_NONE;
            fault_src   <= 2'b00;
            cycle_count <= '0;
        end else begin
            t1_prev <= T1_light;
            case (state)
                ST_ARM: state <= ST_RUN;
                ST_RUN: begin
                    if (t1_entry && cycle_count != 16'hFFFF)
                        cycle_count <= cycle_count + 16'd1;
                    if (code_nxt != FC_NONE) begin
                        state      <= ST_FAULT;
                        fault      <= 1'b1;
                        fault_code <= code_nxt;
                        fault_src  <= src_nxt;
                    end
                end
                default: state <= ST_FAULT;
            endcase
        end
    end
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: scoreboard bench; a behavioural model predicts the
// outputs after every sample and directed checks pin the key scenario results.
module tb_traffic_light_monitor;
    localparam logic [1:0] R = 2'b00, G = 2'b01, Y = 2'b10, X = 2'b11;
    logic clk = 1'b0, rst = 1'b0, el = 1'b0, er = 1'b0, b1 = 1'b0, b2 = 1'b0;
    logic [1:0] t1 = R, t2 = R;
    logic fault;
    logic [2:0] fault_code;
    logic [1:0] fault_src;
    logic [15:0] cycle_count;
    typedef struct packed {logic f; logic [2:0] c; logic [1:0] s; logic [15:0] n;} exp_t;
    exp_t sb[$];
    exp_t m_out;
    int m_st, n_cmp = 0, n_err = 0;
    int m_prev[2], m_dwell[2], m_pend[2], m_wait[2];

    always #5 clk = ~clk;

    traffic_light_monitor dut (
        .clk(clk), .rst(rst), .Emergency_Left(el), .Emergency_Right(er),
        .T1_light(t1), .T2_light(t2), .Buzzer_T1(b1), .Buzzer_T2(b2),
        .fault(fault), .fault_code(fault_code), .fault_src(fault_src), .cycle_count(cycle_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input logic r, input int l0, input int l1, input int e0, input int e1,
                         input int z0, input int z1);
        int l[2], e[2], z[2], code;
        logic [1:0] m[1:6];
        logic ch;
        l = '{l0, l1}; e = '{e0, e1}; z = '{z0, z1};
        if (!r) begin
            m_st = 0; m_prev = '{0, 0}; m_dwell = '{0, 0}; m_pend = '{0, 0}; m_wait = '{0, 0};
            m_out = '0;
            return;
        end
        if (m_st == 0) m_st = 1;
        else if (m_st == 1) begin
            for (int h = 0; h < 2; h++) begin
                ch = l[h] != m_prev[h];
                m[1][h] = l[h] == 3;
                m[3][h] = ch && !((m_prev[h] == 1 && l[h] == 2) || (m_prev[h] == 2 && l[h] == 0) ||
                                  (m_prev[h] == 0 && l[h] == 1));
                m[4][h] = (ch && m_prev[h] == 2 && m_dwell[h] < 2) || (!ch && l[h] == 2 && m_dwell[h] + 1 == 6);
                m[5][h] = ch && m_prev[h] == 1 && m_dwell[h] < 5 && m_pend[h] == 0;
                m[6][h] = m_pend[h] == 1 && m_wait[h] == 3 && z[h] == 0;
            end
            m[2] = (l[0] != 0 && l[1] != 0) ? 2'b11 : 2'b00;
            code = 0;
            for (int k = 6; k >= 1; k--) if (m[k] != 2'b00) code = k;
            if (m_prev[0] == 0 && l[0] == 1 && m_out.n != 16'hFFFF) m_out.n = m_out.n + 16'd1;
            if (code != 0) begin
                m_st = 2; m_out.f = 1'b1; m_out.c = 3'(code); m_out.s = m[code];
            end
        end
        for (int h = 0; h < 2; h++) begin
            m_dwell[h] = (l[h] != m_prev[h]) ? 1 : (m_dwell[h] < 255 ? m_dwell[h] + 1 : 255);
            m_prev[h] = l[h];
            if (z[h] != 0) begin m_pend[h] = 0; m_wait[h] = 0; end
            else if (m_pend[h] != 0) m_wait[h] = m_wait[h] < 255 ? m_wait[h] + 1 : 255;
            else if (e[h] != 0) begin m_pend[h] = 1; m_wait[h] = 0; end
        end
    endtask

    task automatic step(input logic r, input logic [1:0] a, input logic [1:0] b,
                        input logic e0, input logic e1, input logic z0, input logic z1);
        exp_t x;
        rst = r; t1 = a; t2 = b; el = e0; er = e1; b1 = z0; b2 = z1;
        model(r, int'(a), int'(b), int'(e0), int'(e1), int'(z0), int'(z1));
        sb.push_back(m_out);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("fault", 32'(fault), 32'(x.f));
        check("fault_code", 32'(fault_code), 32'(x.c));
        check("fault_src", 32'(fault_src), 32'(x.s));
        check("cycle_count", 32'(cycle_count), 32'(x.n));
    endtask

    task automatic hold(input logic [1:0] a, input logic [1:0] b, input int n);
        repeat (n) step(1'b1, a, b, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic restart();
        step(1'b0, R, R, 1'b0, 1'b0, 1'b0, 1'b0);
        hold(R, R, 1);
    endtask

    initial begin
        // normal alternating operation
        restart();
        check("reset_fault", 32'(fault), 32'd0);
        repeat (3) begin
            hold(G, R, 5); hold(Y, R, 2); hold(R, G, 5); hold(R, Y, 2);
        end
        hold(R, R, 1);
        check("t1_count", 32'(cycle_count), 32'd3);
        check("t1_fault", 32'(fault), 32'd0);
        // GREEN straight to RED
        hold(G, R, 5); hold(R, R, 1);
        check("t2_code", 32'(fault_code), 32'd3);
        check("t2_src", 32'(fault_src), 32'd1);
        // conflict, then later errors must not overwrite it
        restart();
        hold(R, G, 2); hold(Y, G, 1);
        check("t3_code", 32'(fault_code), 32'd2);
        hold(X, X, 2);
        check("t3_sticky", 32'(fault_code), 32'd2);
        check("t3_src", 32'(fault_src), 32'd3);
        // emergency answered in time, then ignored
        restart();
        step(1'b1, R, R, 1'b0, 1'b1, 1'b0, 1'b0);
        hold(R, R, 1);
        step(1'b1, R, R, 1'b0, 1'b0, 1'b0, 1'b1);
        hold(R, R, 6);
        check("t4_ok", 32'(fault), 32'd0);
        step(1'b1, R, R, 1'b0, 1'b1, 1'b0, 1'b0);
        hold(R, R, 3);
        check("t4_pending", 32'(fault), 32'd0);
        hold(R, R, 1);
        check("t4_code", 32'(fault_code), 32'd6);
        check("t4_src", 32'(fault_src), 32'd2);
        // yellow held too long, then reset and clean restart
        restart();
        hold(R, G, 5); hold(R, Y, 5);
        check("t5_y5", 32'(fault), 32'd0);
        hold(R, Y, 1);
        check("t5_code", 32'(fault_code), 32'd4);
        check("t5_src", 32'(fault_src), 32'd2);
        step(1'b0, R, R, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t5_rst_fault", 32'(fault), 32'd0);
        check("t5_rst_code", 32'(fault_code), 32'd0);
        hold(R, R, 1); hold(G, R, 1);
        check("t5_clean", 32'(fault), 32'd0);
        check("t5_count", 32'(cycle_count), 32'd1);
        // illegal code outranks conflict
        restart();
        hold(R, G, 1); hold(X, G, 1);
        check("t6_code", 32'(fault_code), 32'd1);
        check("t6_src", 32'(fault_src), 32'd1);
        // short green waived by pending emergency, then a non-waived short green
        restart();
        step(1'b1, G, R, 1'b1, 1'b0, 1'b0, 1'b0);
        hold(G, R, 2);
        step(1'b1, Y, R, 1'b0, 1'b0, 1'b1, 1'b0);
        hold(Y, R, 1); hold(R, R, 1);
        check("t7_waived", 32'(fault), 32'd0);
        hold(G, R, 2); hold(Y, R, 1);
        check("t7_code", 32'(fault_code), 32'd5);
        check("t7_src", 32'(fault_src), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
